// File: rtl/fpu_pkg.sv
// Shared FP constants and sign-manipulation opcodes used by the FPU issue
// and execute stages.
package fpu_pkg;

    localparam int FSGN_OP_W = 3;
    localparam int FP_W      = 32;
    localparam int SIGN_BIT  = 31;

    localparam logic [FSGN_OP_W-1:0] OP_FABS   = 3'd0;
    localparam logic [FSGN_OP_W-1:0] OP_FNEG   = 3'd1;
    localparam logic [FSGN_OP_W-1:0] OP_FSGNJ  = 3'd2;
    localparam logic [FSGN_OP_W-1:0] OP_FSGNJN = 3'd3;
    localparam logic [FSGN_OP_W-1:0] OP_FSGNJX = 3'd4;
    localparam logic [FSGN_OP_W-1:0] OP_FMV    = 3'd5;

endpackage

// File: rtl/fsgn_arbiter_if.sv
// Request/result bundle between the requesters, the sign arbiter and the
// writeback mux. Request fields are packed per requester.
interface fsgn_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
);
    import fpu_pkg::*;

    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ-1:0]           req_ready;
    logic [FSGN_OP_W*N_REQ-1:0] req_op;
    logic [FP_W*N_REQ-1:0]      req_a;
    logic [FP_W*N_REQ-1:0]      req_b;
    logic                       out_valid;
    logic                       out_ready;
    logic [FP_W-1:0]            out_data;
    logic [ID_W-1:0]            out_id;
    logic                       out_illegal;

    modport slave (
        input  req_valid, req_op, req_a, req_b, out_ready,
        output req_ready, out_valid, out_data, out_id, out_illegal
    );

    modport master (
        output req_valid, req_op, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_data, out_id, out_illegal
    );

endinterface

// File: rtl/fsgn_unit.sv
// Combinational fabs/fneg/fsgnj* datapath: only the sign bit of a is ever
// changed, so NaN/inf/denormal payloads pass through untouched.
module fsgn_unit
    import fpu_pkg::*;
(
    input  logic [FSGN_OP_W-1:0] op,
    input  logic [FP_W-1:0]      a,
    input  logic [FP_W-1:0]      b,
    output logic [FP_W-1:0]      result,
    output logic                 illegal
);

    logic s;
    logic t;
    logic sign;

    // Only the sign of b feeds the result; its payload is deliberately ignored.
    logic unused_b_payload;
    assign unused_b_payload = ^b[SIGN_BIT-1:0];

    assign s = a[SIGN_BIT];
    assign t = b[SIGN_BIT];

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        sign    = s;
        illegal = 1'b0;
        case (op)
            OP_FABS:   sign = 1'b0;
            OP_FNEG:   sign = ~s;
            OP_FSGNJ:  sign = t;
            OP_FSGNJN: sign = ~t;
            OP_FSGNJX: sign = s ^ t;
            OP_FMV:    sign = s;
            default:   illegal = 1'b1;
        endcase
        result = {sign, a[SIGN_BIT-1:0]};
    end

endmodule

// File: rtl/fsgn_arbiter.sv
// Round-robin arbiter sharing one fsgn_unit among N_REQ requesters, with a
// single registered result slot behind a valid/ready handshake.
module fsgn_arbiter
    import fpu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic           clk,
    input  logic           rst,
    fsgn_arbiter_if.slave  bus
);

    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      gnt_id;
    logic [N_REQ-1:0]     grant;
    logic                 found;
    logic                 slot_free;
    logic                 fire;
    int                   idx;

    logic [FSGN_OP_W-1:0] sel_op;
    logic [FP_W-1:0]      sel_a;
    logic [FP_W-1:0]      sel_b;
    logic [FP_W-1:0]      result;
    logic                 illegal;

    logic                 out_valid_q;
    logic [FP_W-1:0]      out_data_q;
    logic [ID_W-1:0]      out_id_q;
    logic                 out_illegal_q;

    assign slot_free = !out_valid_q || bus.out_ready;

    // Scan rr_ptr, rr_ptr+1, ... (mod N_REQ) for the first valid requester.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        gnt_id = '0;
        idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                gnt_id     = ID_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    assign fire          = found && slot_free;
    assign bus.req_ready = (slot_free && !rst) ? grant : '0;

    assign sel_op = bus.req_op[gnt_id*FSGN_OP_W +: FSGN_OP_W];
    assign sel_a  = bus.req_a[gnt_id*FP_W +: FP_W];
    assign sel_b  = bus.req_b[gnt_id*FP_W +: FP_W];

    fsgn_unit u_unit (
        .op      (sel_op),
        .a       (sel_a),
        .b       (sel_b),
        .result  (result),
        .illegal (illegal)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr        <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_id_q      <= '0;
            out_illegal_q <= 1'b0;
        end else if (fire) begin
            out_valid_q   <= 1'b1;
            out_data_q    <= result;
            out_id_q      <= gnt_id;
            out_illegal_q <= illegal;
            rr_ptr        <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
        end else if (bus.out_ready) begin
            // Consumed with nothing to reload: data is kept, only valid drops.
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_id      = out_id_q;
    assign bus.out_illegal = out_illegal_q;

endmodule

// File: tb/tb_fsgn_arbiter.sv
// Directed scenarios plus randomized traffic against a behavioural model for
// the sign arbiter, on a 2-requester and a 3-requester instance.
module tb_fsgn_arbiter;
    import fpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fsgn_arbiter_if #(.N_REQ(2), .ID_W(1)) bus2 ();
    fsgn_arbiter_if #(.N_REQ(3), .ID_W(2)) bus3 ();

    fsgn_arbiter #(.N_REQ(2), .ID_W(1)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    fsgn_arbiter #(.N_REQ(3), .ID_W(2)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    // Behavioural sign rule: returns {illegal, result}.
    function automatic logic [32:0] fsgn_ref(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic sgn;
        logic ill;
        ill = 1'b0;
        case (op)
            3'd0:    sgn = 1'b0;
            3'd1:    sgn = !a[31];
            3'd2:    sgn = b[31];
            3'd3:    sgn = !b[31];
            3'd4:    sgn = (a[31] != b[31]);
            3'd5:    sgn = a[31];
            default: begin sgn = a[31]; ill = 1'b1; end
        endcase
        return {ill, sgn, a[30:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set2(input int i, input logic v, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
        bus2.req_valid[i]      = v;
        bus2.req_op[3*i +: 3]  = op;
        bus2.req_a[32*i +: 32] = a;
        bus2.req_b[32*i +: 32] = b;
    endtask

    task automatic set3(input int i, input logic v, input logic [31:0] a);
        bus3.req_valid[i]      = v;
        bus3.req_op[3*i +: 3]  = OP_FMV;
        bus3.req_a[32*i +: 32] = a;
        bus3.req_b[32*i +: 32] = 32'h0;
    endtask

    task automatic test_reset();
        bus2.req_valid = 2'b11;
        bus3.req_valid = 3'b111;
        bus2.out_ready = 1'b1;
        bus3.out_ready = 1'b1;
        #12;
        checks++; if (bus2.req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready2: got %b expected 00", bus2.req_ready); end
        checks++; if (bus3.req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready3: got %b expected 000", bus3.req_ready); end
        checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus2.out_valid); end
        checks++; if (bus2.out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus2.out_data); end
        checks++; if (bus2.out_id !== 1'b0) begin errors++; $display("FAIL reset_id: got %h expected 0", bus2.out_id); end
        checks++; if (bus2.out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", bus2.out_illegal); end
        bus2.req_valid = 2'b00;
        bus3.req_valid = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_fabs();
        bus2.out_ready = 1'b1;
        set2(0, 1'b1, OP_FABS, 32'hC0490FDB, 32'h0);
        #1;
        checks++; if (bus2.req_ready !== 2'b01) begin errors++; $display("FAIL fabs_ready: got %b expected 01", bus2.req_ready); end
        tick();
        set2(0, 1'b0, OP_FABS, 32'h0, 32'h0);
        checks++; if (bus2.out_valid !== 1'b1) begin errors++; $display("FAIL fabs_valid: got %b expected 1", bus2.out_valid); end
        checks++; if (bus2.out_data !== 32'h40490FDB) begin errors++; $display("FAIL fabs_data: got %h expected 40490fdb", bus2.out_data); end
        checks++; if (bus2.out_id !== 1'b0) begin errors++; $display("FAIL fabs_id: got %h expected 0", bus2.out_id); end
        checks++; if (bus2.out_illegal !== 1'b0) begin errors++; $display("FAIL fabs_illegal: got %b expected 0", bus2.out_illegal); end
    endtask

    task automatic test_op_sweep();
        logic [31:0] exp_tab [9];
        logic [31:0] a;
        logic [2:0]  op;
        exp_tab = '{32'h3F800000, 32'hBF800000, 32'hBF800000, 32'h3F800000, 32'hBF800000,
                    32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hFFC00001};
        for (int k = 0; k < 9; k++) begin
            a  = (k == 8) ? 32'h7FC00001 : 32'h3F800000;
            op = (k == 8) ? OP_FNEG : 3'(k);
            set2(1, 1'b1, op, a, 32'hBF800000);
            #1;
            checks++; if (bus2.req_ready !== 2'b10) begin errors++; $display("FAIL sweep_ready[%0d]: got %b expected 10", k, bus2.req_ready); end
            tick();
            checks++; if (bus2.out_data !== exp_tab[k]) begin errors++; $display("FAIL sweep_data[%0d]: got %h expected %h", k, bus2.out_data, exp_tab[k]); end
            checks++; if (bus2.out_illegal !== (k == 6 || k == 7)) begin errors++; $display("FAIL sweep_illegal[%0d]: got %b", k, bus2.out_illegal); end
            checks++; if (bus2.out_id !== 1'b1 || bus2.out_valid !== 1'b1) begin errors++; $display("FAIL sweep_id[%0d]: got id %h valid %b expected 1 1", k, bus2.out_id, bus2.out_valid); end
        end
        set2(1, 1'b0, OP_FABS, 32'h0, 32'h0);
        tick();
        checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b expected 0", bus2.out_valid); end
        checks++; if (bus2.out_data !== 32'hFFC00001) begin errors++; $display("FAIL drain_data_kept: got %h expected ffc00001", bus2.out_data); end
    endtask

    task automatic test_fairness();
        int e;
        bus2.out_ready = 1'b1;
        set2(0, 1'b1, OP_FMV, 32'h11111111, 32'h0);
        set2(1, 1'b1, OP_FMV, 32'h22222222, 32'h0);
        for (int k = 0; k < 8; k++) begin
            e = k % 2;
            #1;
            checks++; if (bus2.req_ready !== ((e == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair_ready[%0d]: got %b expected grant %0d", k, bus2.req_ready, e); end
            tick();
            checks++; if (bus2.out_valid !== 1'b1 || bus2.out_id !== 1'(e)) begin errors++; $display("FAIL fair_id[%0d]: got id %h valid %b expected %0d", k, bus2.out_id, bus2.out_valid, e); end
            checks++; if (bus2.out_data !== ((e == 1) ? 32'h22222222 : 32'h11111111)) begin errors++; $display("FAIL fair_data[%0d]: got %h", k, bus2.out_data); end
        end
    endtask

    task automatic test_backpressure();
        bus2.out_ready = 1'b0;
        #1;
        checks++; if (bus2.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready0: got %b expected 00", bus2.req_ready); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (bus2.out_valid !== 1'b1 || bus2.out_data !== 32'h22222222) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h valid %b expected 22222222", k, bus2.out_data, bus2.out_valid); end
            checks++; if (bus2.out_id !== 1'b1 || bus2.out_illegal !== 1'b0) begin errors++; $display("FAIL bp_hold_id[%0d]: got id %h ill %b expected 1 0", k, bus2.out_id, bus2.out_illegal); end
            checks++; if (bus2.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 00", k, bus2.req_ready); end
        end
        bus2.out_ready = 1'b1;
        #1;
        checks++; if (bus2.req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_ready: got %b expected 01", bus2.req_ready); end
        tick();
        checks++; if (bus2.out_valid !== 1'b1 || bus2.out_id !== 1'b0 || bus2.out_data !== 32'h11111111) begin errors++; $display("FAIL bp_release_out: got valid %b id %h data %h expected 1 0 11111111", bus2.out_valid, bus2.out_id, bus2.out_data); end
        bus2.req_valid = 2'b00;
        tick();
    endtask

    task automatic test_ptr_hold();
        set2(1, 1'b1, OP_FMV, 32'h33333333, 32'h0);
        #1;
        checks++; if (bus2.req_ready !== 2'b10) begin errors++; $display("FAIL hold_ready1: got %b expected 10", bus2.req_ready); end
        tick();
        set2(1, 1'b0, OP_FMV, 32'h0, 32'h0);
        checks++; if (bus2.out_id !== 1'b1 || bus2.out_data !== 32'h33333333) begin errors++; $display("FAIL hold_out1: got id %h data %h expected 1 33333333", bus2.out_id, bus2.out_data); end
        tick();
        tick();
        checks++; if (bus2.out_valid !== 1'b0) begin errors++; $display("FAIL hold_idle_valid: got %b expected 0", bus2.out_valid); end
        set2(0, 1'b1, OP_FMV, 32'h44444444, 32'h0);
        set2(1, 1'b1, OP_FMV, 32'h55555555, 32'h0);
        #1;
        checks++; if (bus2.req_ready !== 2'b01) begin errors++; $display("FAIL hold_ready_both: got %b expected 01", bus2.req_ready); end
        tick();
        checks++; if (bus2.out_id !== 1'b0 || bus2.out_data !== 32'h44444444) begin errors++; $display("FAIL hold_out_both: got id %h data %h expected 0 44444444", bus2.out_id, bus2.out_data); end
        bus2.req_valid = 2'b00;
        tick();
    endtask

    task automatic test_wrap3();
        int seq [4];
        seq = '{0, 1, 2, 0};
        bus3.out_ready = 1'b1;
        set3(2, 1'b1, 32'hA2A2A2A2);
        #1;
        checks++; if (bus3.req_ready !== 3'b100) begin errors++; $display("FAIL wrap_ready2: got %b expected 100", bus3.req_ready); end
        tick();
        checks++; if (bus3.out_id !== 2'd2 || bus3.out_data !== 32'hA2A2A2A2) begin errors++; $display("FAIL wrap_out2: got id %h data %h expected 2 a2a2a2a2", bus3.out_id, bus3.out_data); end
        set3(0, 1'b1, 32'hA0A0A0A0);
        set3(1, 1'b1, 32'hA1A1A1A1);
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus3.req_ready !== 3'(1 << seq[k])) begin errors++; $display("FAIL wrap_ready[%0d]: got %b expected grant %0d", k, bus3.req_ready, seq[k]); end
            tick();
            checks++; if (bus3.out_id !== 2'(seq[k]) || bus3.out_valid !== 1'b1) begin errors++; $display("FAIL wrap_id[%0d]: got %h expected %0d", k, bus3.out_id, seq[k]); end
        end
        bus3.req_valid = 3'b000;
        tick();
    endtask

    task automatic test_reset_mid();
        bus2.out_ready = 1'b0;
        bus3.out_ready = 1'b0;
        set2(1, 1'b1, OP_FNEG, 32'h66666666, 32'h0);
        set3(1, 1'b1, 32'h77777777);
        tick();
        bus2.req_valid = 2'b00;
        bus3.req_valid = 3'b000;
        checks++; if (bus2.out_valid !== 1'b1 || bus2.out_id !== 1'b1 || bus2.out_data !== 32'hE6666666) begin errors++; $display("FAIL pre_reset_out: got valid %b id %h data %h expected 1 1 e6666666", bus2.out_valid, bus2.out_id, bus2.out_data); end
        tick();
        bus2.req_valid = 2'b11;
        bus3.req_valid = 3'b111;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus2.out_valid !== 1'b0 || bus2.out_data !== 32'h0) begin errors++; $display("FAIL async_rst_out2: got valid %b data %h expected 0 0", bus2.out_valid, bus2.out_data); end
        checks++; if (bus2.out_id !== 1'b0 || bus2.req_ready !== 2'b00) begin errors++; $display("FAIL async_rst_id2: got id %h ready %b expected 0 00", bus2.out_id, bus2.req_ready); end
        checks++; if (bus3.out_valid !== 1'b0 || bus3.out_id !== 2'd0 || bus3.req_ready !== 3'b000) begin errors++; $display("FAIL async_rst3: got valid %b id %h ready %b", bus3.out_valid, bus3.out_id, bus3.req_ready); end
        #3;
        rst = 1'b0;
        bus2.out_ready = 1'b1;
        bus3.out_ready = 1'b1;
        #1;
        checks++; if (bus2.req_ready !== 2'b01) begin errors++; $display("FAIL post_rst_ready2: got %b expected 01", bus2.req_ready); end
        checks++; if (bus3.req_ready !== 3'b001) begin errors++; $display("FAIL post_rst_ready3: got %b expected 001", bus3.req_ready); end
        tick();
        checks++; if (bus2.out_id !== 1'b0 || bus3.out_id !== 2'd0 || bus2.out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_id: got %h %h expected 0 0", bus2.out_id, bus3.out_id); end
        bus2.req_valid = 2'b00;
        bus3.req_valid = 3'b000;
        tick();
    endtask

    task automatic drive(input int n, input logic [7:0] v, input logic [2:0] op [8],
                         input logic [31:0] a [8], input logic [31:0] b [8], input logic orr);
        if (n == 2) begin
            bus2.out_ready = orr;
            for (int i = 0; i < 2; i++) begin
                bus2.req_valid[i]      = v[i];
                bus2.req_op[3*i +: 3]  = op[i];
                bus2.req_a[32*i +: 32] = a[i];
                bus2.req_b[32*i +: 32] = b[i];
            end
        end else begin
            bus3.out_ready = orr;
            for (int i = 0; i < 3; i++) begin
                bus3.req_valid[i]      = v[i];
                bus3.req_op[3*i +: 3]  = op[i];
                bus3.req_a[32*i +: 32] = a[i];
                bus3.req_b[32*i +: 32] = b[i];
            end
        end
    endtask

    task automatic test_random(input int n, input int cycles);
        logic [7:0]  v;
        logic [2:0]  op [8];
        logic [31:0] a [8];
        logic [31:0] b [8];
        logic        orr;
        logic        m_valid, m_ill;
        logic [31:0] m_data;
        logic [32:0] r;
        int          m_id, m_ptr, g, oid;
        logic [7:0]  rdy, rdy_exp;
        logic        ov, oill;
        logic [31:0] od;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_valid = 1'b0; m_ill = 1'b0; m_data = 32'h0; m_id = 0; m_ptr = 0;
        for (int i = 0; i < 8; i++) begin
            v[i] = ($urandom_range(0, 9) < 6); op[i] = 3'($urandom); a[i] = $urandom; b[i] = $urandom;
        end
        orr = ($urandom_range(0, 3) != 0);
        drive(n, v, op, a, b, orr);
        repeat (cycles) begin
            @(negedge clk);
            if (n == 2) begin
                rdy = {6'b0, bus2.req_ready}; ov = bus2.out_valid; od = bus2.out_data;
                oid = int'(bus2.out_id); oill = bus2.out_illegal;
            end else begin
                rdy = {5'b0, bus3.req_ready}; ov = bus3.out_valid; od = bus3.out_data;
                oid = int'(bus3.out_id); oill = bus3.out_illegal;
            end
            checks++; if (ov !== m_valid) begin errors++; $display("FAIL rnd%0d_valid: got %b expected %b", n, ov, m_valid); end
            checks++; if (od !== m_data || oill !== m_ill) begin errors++; $display("FAIL rnd%0d_data: got %h/%b expected %h/%b", n, od, oill, m_data, m_ill); end
            checks++; if (oid != m_id) begin errors++; $display("FAIL rnd%0d_id: got %0d expected %0d", n, oid, m_id); end

            g = -1;
            if (!m_valid || orr)
                for (int k = 0; k < n; k++)
                    if (g < 0 && v[(m_ptr + k) % n]) g = (m_ptr + k) % n;
            rdy_exp = (g >= 0) ? 8'(1 << g) : 8'h0;
            checks++; if (rdy !== rdy_exp) begin errors++; $display("FAIL rnd%0d_ready: got %b expected %b", n, rdy, rdy_exp); end

            if (g >= 0) begin
                r = fsgn_ref(op[g], a[g], b[g]);
                m_ill = r[32]; m_data = r[31:0]; m_valid = 1'b1; m_id = g; m_ptr = (g + 1) % n;
            end else if (orr) begin
                m_valid = 1'b0;
            end

            // Pending requests stay frozen until accepted.
            for (int i = 0; i < n; i++) begin
                if (!v[i] || i == g) begin
                    v[i] = ($urandom_range(0, 9) < 6); op[i] = 3'($urandom); a[i] = $urandom; b[i] = $urandom;
                end
            end
            orr = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            drive(n, v, op, a, b, orr);
        end
        bus2.req_valid = '0;
        bus3.req_valid = '0;
        tick();
    endtask

    initial begin
        bus2.req_valid = '0; bus2.req_op = '0; bus2.req_a = '0; bus2.req_b = '0; bus2.out_ready = 1'b0;
        bus3.req_valid = '0; bus3.req_op = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.out_ready = 1'b0;
        test_reset();
        test_single_fabs();
        test_op_sweep();
        test_fairness();
        test_backpressure();
        test_ptr_hold();
        test_wrap3();
        test_reset_mid();
        test_random(2, 500);
        test_random(3, 500);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsgn_arbiter.md
Name: fsgn_arbiter

Overview:
- Shares one combinational sign-manipulation datapath (fabs/fneg/fsgnj family) among N_REQ requesters, e.g. the integer pipe and the FPU issue stage.
- Arbitration is round-robin; the result is registered and tagged with the requester id, behind a valid/ready output handshake.
- Sits between the FPU issue logic and the FP register-file writeback mux.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of requester id; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  N_REQ  per-requester request valid.
- req_ready  output  N_REQ  per-requester accept; one-hot or zero.
- req_op  input  3*N_REQ  packed per-requester opcode; requester i at [3i+2:3i].
- req_a  input  32*N_REQ  packed operand a (IEEE-754 single).
- req_b  input  32*N_REQ  packed operand b; sign source for fsgnj*.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  32  result.
- out_id  output  ID_W  index of the requester that produced out_data.
- out_illegal  output  1  opcode was undefined.

Behaviour:
- Opcodes (3 bits), with s = a[31], t = b[31]:
  - 0 FABS → {0, a[30:0]}
  - 1 FNEG → {~s, a[30:0]}
  - 2 FSGNJ → {t, a[30:0]}
  - 3 FSGNJN → {~t, a[30:0]}
  - 4 FSGNJX → {s^t, a[30:0]}
  - 5 FMV → a
  - 6, 7 illegal → a passed through, out_illegal=1.
- NaN/inf/denormal payloads pass untouched; only bit 31 is altered. No exception flags.
- Slot free condition: slot_free = !out_valid || out_ready (combinational).
- Grant, when slot_free:
  - Grant the first i with req_valid[i], scanning rr_ptr, rr_ptr+1, … mod N_REQ.
  - req_ready = one-hot grant.
  - If !slot_free, req_ready = 0.
- A handshake occurs on req_valid[i] && req_ready[i]. On that edge:
  - out_data, out_illegal and out_id are loaded; out_valid is set to 1.
  - rr_ptr becomes (i+1) mod N_REQ.
- Latency: result visible exactly 1 cycle after the handshake.
- Throughput: 1 result per cycle while out_ready stays high.
- Output hold: if out_valid && !out_ready, out_data, out_id and out_illegal hold stable. No new grant until consumed.
- Simultaneous consume and grant: the slot is reloaded in the same edge and out_valid stays 1, with no bubble.
- Consume with no request: out_valid goes to 0; out_data keeps its last value.
- req_ready is not combinationally dependent on req_valid of other requesters beyond the priority scan. No combinational path from out_ready to out_data.
- rr_ptr advances only on a grant. Idle cycles leave it unchanged. Wrap-around: N_REQ-1 → 0.
- A requester must hold its valid, op and operands stable until accepted; the arbiter does not latch unaccepted requests.
- Reset values: out_valid=0, out_data=32'h0, out_id=0, out_illegal=0, rr_ptr=0.
- Reset mid-operation: the pending result is dropped and not replayed. req_ready=0 while rst is high.

Decomposition:
- Shared package fpu_pkg holds:
  - FSGN_OP_W=3;
  - opcode constants OP_FABS, OP_FNEG, OP_FSGNJ, OP_FSGNJN, OP_FSGNJX, OP_FMV;
  - FP_W=32 and SIGN_BIT=31.
- Sub-module fsgn_unit: purely combinational (op, a, b) → (result, illegal). It is reusable by the FPU execute stage.
- The arbiter holds only the round-robin scan, rr_ptr and the output register.

Test Plan:
1. Single requester, FABS:
   - Req 0 with op=0, a=32'hC0490FDB, out_ready=1.
   - Expect: req_ready[0]=1 in the same cycle; next cycle out_valid=1, out_data=32'h40490FDB, out_id=0, out_illegal=0.
2. Full op sweep on req 1, with a=32'h3F800000, b=32'hBF800000:
   - Required results for ops 0..5: 3F800000, BF800000, BF800000, 3F800000, BF800000, 3F800000.
   - ops 6 and 7: out_data=3F800000 with out_illegal=1.
   - NaN check: a=7FC00001, op=1 → FFC00001.
3. Fairness, N_REQ=2:
   - Both valid continuously, out_ready=1.
   - Expect grants 0,1,0,1… and out_id alternating 0,1,0,1 each cycle with no idle cycles.
4. Backpressure:
   - out_ready=0 for 3 cycles with out_valid=1.
   - Expect out_data, out_id, out_illegal constant and req_ready=0 throughout.
   - Raise out_ready: the next grant occurs in the same cycle and out_valid stays 1.
5. Pointer hold and wrap:
   - Grant req 1 (rr_ptr→0), then 2 idle cycles, then both valid.
   - Expect req 0 granted first.
   - N_REQ=3: grant req 2 → rr_ptr=0.
6. Reset mid-operation:
   - Assert rst asynchronously while out_valid=1 and out_ready=0.
   - Expect out_valid=0, out_data=0, out_id=0 and req_ready=0 immediately, without waiting for a clock edge.
   - After release, the first grant goes to req 0 when both request.
